counter_seq_checker: RTL and testbench

COUNTER_SEQ_CHECKER -- requirements
Module: counter_seq_checker

---
 rtl/counter_seq_checker.sv | 162 ++++++++++++++++
 tb/tb_counter_seq_checker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_checker.sv
// Sequence checker for a 3-bit counter word received as C/B/A.
// Build option: SEQ_CHECK_ERRCNT_EN enables the saturating ERR_CNT register.
module counter_seq_checker (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       C,
  input  logic       B,
  input  logic       A,
  output logic [2:0] IDX,
  output logic       LOCK,
  output logic       ERR,
  output logic       WRAP,
  output logic [7:0] ERR_CNT
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [1:0] match_q, match_d;
  logic       miss_q, miss_d;
  logic [2:0] idx_q, idx_d;
  logic       lock_q, lock_d;
  logic       err_q, err_d;
  logic       wrap_q, wrap_d;

  logic [2:0] idx_w;
  logic       hit_w;

  // Map the received word onto its position in the step sequence.
  always_comb begin
    idx_w = 3'd0;
    unique case ({C, B, A})
      3'b000:  idx_w = 3'd0;
      3'b111:  idx_w = 3'd1;
      3'b001:  idx_w = 3'd2;
      3'b110:  idx_w = 3'd3;
      3'b010:  idx_w = 3'd4;
      3'b101:  idx_w = 3'd5;
      3'b011:  idx_w = 3'd6;
      3'b100:  idx_w = 3'd7;
      default: idx_w = 3'd0;
    endcase
  end

  // A hit is the modulo-8 successor; a repeated word is never a hit.
  assign hit_w = (idx_w == (prev_q + 3'd1));

  // Next-state and output decode; pulses default low and state holds.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    match_d = match_q;
    miss_d  = miss_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (EN) begin
      idx_d  = idx_w;
      prev_d = idx_w;
      unique case (state_q)
        HUNT: begin
          match_d = 2'd0;
          state_d = CONFIRM;
        end
        CONFIRM: begin
          if (hit_w) begin
            if (match_q == 2'd2) begin
              state_d = LOCKED;
              match_d = 2'd0;
              miss_d  = 1'b0;
            end else begin
              match_d = match_q + 2'd1;
            end
          end else begin
            match_d = 2'd0;
          end
        end
        LOCKED: begin
          if (hit_w) begin
            miss_d = 1'b0;
            wrap_d = (prev_q == 3'd7);
          end else begin
            err_d = 1'b1;
            if (miss_q) begin
              state_d = CONFIRM;
              match_d = 2'd0;
              miss_d  = 1'b0;
            end else begin
              miss_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          match_d = 2'd0;
          miss_d  = 1'b0;
        end
      endcase
    end
    lock_d = (state_d == LOCKED);
  end

  // Core state and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= HUNT;
      prev_q  <= 3'd0;
      match_q <= 2'd0;
      miss_q  <= 1'b0;
      idx_q   <= 3'd0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      idx_q   <= idx_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef SEQ_CHECK_ERRCNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Violation count sticks at 255 while ERR keeps pulsing.
  always_comb begin
    cnt_d = cnt_q;
    if (err_d && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Violation counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ERR_CNT = cnt_q;
`else
  assign ERR_CNT = 8'd0;
`endif

  assign IDX  = idx_q;
  assign LOCK = lock_q;
  assign ERR  = err_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Scoreboard bench for counter_seq_checker.
// Expected outputs come from a behavioural model queued per sample.
module tb_counter_seq_checker;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       C = 1'b0;
  logic       B = 1'b0;
  logic       A = 1'b0;
  logic [2:0] IDX;
  logic       LOCK;
  logic       ERR;
  logic       WRAP;
  logic [7:0] ERR_CNT;

  counter_seq_checker dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .C(C), .B(B), .A(A),
    .IDX(IDX), .LOCK(LOCK), .ERR(ERR),
    .WRAP(WRAP), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] idx;
    logic       lock;
    logic       err;
    logic       wrap;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_run = 0;
  int   n_fail = 0;

  logic [2:0] enc [8] = '{3'b000, 3'b111, 3'b001, 3'b110,
                          3'b010, 3'b101, 3'b011, 3'b100};

  int   m_st;
  int   m_prev;
  int   m_match;
  bit   m_miss;
  exp_t m_out;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(bit rst, bit en, logic [2:0] w);
    int idx;
    idx = 0;
    if (rst) begin
      m_st = 0; m_prev = 0; m_match = 0; m_miss = 0;
      m_out = '0;
    end else if (en) begin
      for (int i = 0; i < 8; i++) if (enc[i] == w) idx = i;
      m_out.err = 0;
      m_out.wrap = 0;
      m_out.idx = idx[2:0];
      if (m_st == 0) begin
        m_match = 0;
        m_st = 1;
      end else if (m_st == 1) begin
        if (idx == (m_prev + 1) % 8) begin
          m_match++;
          if (m_match == 3) begin
            m_st = 2; m_match = 0; m_miss = 0;
          end
        end else begin
          m_match = 0;
        end
      end else begin
        if (idx == (m_prev + 1) % 8) begin
          m_miss = 0;
          m_out.wrap = (m_prev == 7);
        end else begin
          m_out.err = 1;
`ifdef SEQ_CHECK_ERRCNT_EN
          if (m_out.cnt != 8'd255) m_out.cnt = m_out.cnt + 8'd1;
`endif
          if (m_miss) begin
            m_st = 1; m_match = 0; m_miss = 0;
          end else begin
            m_miss = 1;
          end
        end
      end
      m_prev = idx;
      m_out.lock = (m_st == 2);
    end else begin
      m_out.err = 0;
      m_out.wrap = 0;
    end
  endtask

  task automatic drive(bit rst, bit en, logic [2:0] w);
    exp_t e;
    RST = rst;
    EN = en;
    {C, B, A} = w;
    model(rst, en, w);
    sb_q.push_back(m_out);
    @(posedge CLK);
    @(negedge CLK);
    e = sb_q.pop_front();
    check("IDX", 32'(IDX), 32'(e.idx));
    check("LOCK", 32'(LOCK), 32'(e.lock));
    check("ERR", 32'(ERR), 32'(e.err));
    check("WRAP", 32'(WRAP), 32'(e.wrap));
    check("ERR_CNT", 32'(ERR_CNT), 32'(e.cnt));
    check("ERR_WRAP_EXCL", 32'(ERR & WRAP), 32'd0);
  endtask

  task automatic dw(int i);
    drive(1'b0, 1'b1, enc[i % 8]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sat_exp;
    m_out = '0;
    @(negedge CLK);
    drive(1'b1, 1'b1, 3'b111);
    drive(1'b1, 1'b0, 3'b000);
    // acquire
    dw(0); dw(1); dw(2); dw(3);
    check("LOCK_AFTER_110", 32'(LOCK), 32'd1);
    // run through wrap
    dw(4); dw(5); dw(6); dw(7); dw(0);
    check("WRAP_AT_0", 32'(WRAP), 32'd1);
    // single bad word then resume
    dw(1); dw(2); dw(4); dw(5);
    check("LOCK_AFTER_1ERR", 32'(LOCK), 32'd1);
    // two bad words drop lock
    dw(6); dw(7); dw(0); dw(1); dw(2); dw(3);
    dw(1); dw(0);
    check("UNLOCK_2ERR", 32'(LOCK), 32'd0);
    // repeated word in CONFIRM, then relock
    dw(0); dw(1); dw(2); dw(3);
    // EN gating
    dw(4);
    drive(1'b0, 1'b0, 3'b111);
    drive(1'b0, 1'b0, 3'b000);
    dw(5);
    // reset with EN high
    drive(1'b1, 1'b1, enc[6]);
    check("RST_LOCK", 32'(LOCK), 32'd0);
    // full re-acquisition after reset
    dw(5); dw(6); dw(7);
    check("REACQ_NOT_YET", 32'(LOCK), 32'd0);
    dw(0);
    check("REACQ_LOCK", 32'(LOCK), 32'd1);
    // a few random samples with random EN
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    // relock, then force violations in pairs
    dw(m_prev + 1); dw(m_prev + 1); dw(m_prev + 1);
    if (m_st != 2) begin
      dw(m_prev + 1); dw(m_prev + 1); dw(m_prev + 1);
    end
    for (int r = 0; r < 150; r++) begin
      dw(m_prev); dw(m_prev);
      dw(m_prev + 1); dw(m_prev + 1); dw(m_prev + 1);
    end
`ifdef SEQ_CHECK_ERRCNT_EN
    sat_exp = 8'd255;
`else
    sat_exp = 8'd0;
`endif
    check("ERR_CNT_SAT", 32'(ERR_CNT), 32'(sat_exp));
    dw(m_prev);
    check("ERR_PULSE_SAT", 32'(ERR), 32'd1);
    check("SB_EMPTY", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
